pe_reduce_sum: RTL and testbench



---
 rtl/pe_pkg.sv | 15 +
 rtl/pe_sync_fifo.sv | 59 +++++
 rtl/pe_reduce_sum.sv | 154 +++++++++++++++
 tb/tb_pe_reduce_sum.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and constants for the PE vector chain.
package pe_pkg;

    localparam int unsigned LANES = 8;
    localparam int unsigned W     = 64;

    typedef logic [W-1:0]      lane_t;
    typedef lane_t [LANES-1:0] vec_t;

    typedef enum logic {
        IDLE,
        ACC
    } state_e;

endpackage

// File: rtl/pe_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with occupancy count.
module pe_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wr_en_i,
    input  logic [DW-1:0]            wr_data_i,
    input  logic                     rd_en_i,
    output logic [DW-1:0]            rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_wr;
    logic          do_rd;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a write alongside it.
    assign do_rd = rd_en_i & ~empty_o;
    assign do_wr = wr_en_i & (~full_o | do_rd);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pe_reduce_sum.sv
// Buffers vector beats, sums lanes in a 3-stage adder tree and accumulates one scalar per packet.
module pe_reduce_sum
    import pe_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BP_THRESH  = 10,
    parameter int unsigned LEN_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  vec_t             D,
    input  logic             D_VALID,
    output logic             D_BP,
    input  logic [LEN_W-1:0] LEN,
    output lane_t            Q,
    output logic             Q_VALID,
    input  logic             Q_BP,
    output logic             ERR
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    vec_t             fifo_data;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    lane_t [3:0]      s1_q;
    lane_t [1:0]      s2_q;
    lane_t            s3_q;
    logic             v1_q, v2_q, v3_q;

    state_e           state_q, state_d;
    lane_t            acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] len_eff;
    lane_t            q_q, q_d;
    logic             qv_q, qv_d;
    logic             err_q, err_d;

    assign pop  = ~fifo_empty & ~Q_BP;
    assign D_BP = (fifo_count >= CW'(BP_THRESH));

    pe_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (LANES * W)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .wr_en_i   (D_VALID),
        .wr_data_i (D),
        .rd_en_i   (pop),
        .rd_data_o (fifo_data),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Adder tree: data registers only load when their stage carries a valid beat.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            v1_q <= pop;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (pop) begin
                for (int i = 0; i < 4; i++) begin
                    s1_q[i] <= fifo_data[2*i] + fifo_data[2*i+1];
                end
            end
            if (v1_q) begin
                s2_q[0] <= s1_q[0] + s1_q[1];
                s2_q[1] <= s1_q[2] + s1_q[3];
            end
            if (v2_q) begin
                s3_q <= s2_q[0] + s2_q[1];
            end
        end
    end

    assign len_eff = (LEN == '0) ? LEN_W'(1) : LEN;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        q_d     = q_q;
        qv_d    = 1'b0;
        err_d   = err_q | (D_VALID & fifo_full & ~pop);
        case (state_q)
            IDLE: begin
                if (v3_q) begin
                    len_d = len_eff;
                    if (len_eff == LEN_W'(1)) begin
                        q_d  = s3_q;
                        qv_d = 1'b1;
                    end else begin
                        acc_d   = s3_q;
                        cnt_d   = LEN_W'(1);
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (v3_q) begin
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        q_d     = acc_q + s3_q;
                        qv_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        acc_d = acc_q + s3_q;
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            q_q     <= '0;
            qv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
            err_q   <= err_d;
        end
    end

    assign Q       = q_q;
    assign Q_VALID = qv_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_pe_reduce_sum.sv
// Randomized bench for pe_reduce_sum against a packet-sum reference model.
module tb_pe_reduce_sum;
    import pe_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    vec_t        D;
    logic        D_VALID;
    logic        D_BP;
    logic [15:0] LEN;
    lane_t       Q;
    logic        Q_VALID;
    logic        Q_BP;
    logic        ERR;

    int          passed = 0;
    int          total  = 0;
    int unsigned cyc    = 0;
    lane_t       got_q[$];
    int unsigned got_t[$];

    pe_reduce_sum dut (
        .CLK     (CLK),
        .RST     (RST),
        .D       (D),
        .D_VALID (D_VALID),
        .D_BP    (D_BP),
        .LEN     (LEN),
        .Q       (Q),
        .Q_VALID (Q_VALID),
        .Q_BP    (Q_BP),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    always @(posedge CLK) begin
        #1;
        if (Q_VALID === 1'b1) begin
            got_q.push_back(Q);
            got_t.push_back(cyc);
        end
    end

    // Reference: a beat contributes the plain modulo-2^64 sum of its lanes.
    function automatic lane_t beat_sum(input vec_t v);
        lane_t s = '0;
        for (int i = 0; i < int'(LANES); i++) s += v[i];
        return s;
    endfunction

    function automatic vec_t seq_vec();
        vec_t v;
        for (int i = 0; i < int'(LANES); i++) v[i] = 64'(i + 1);
        return v;
    endfunction

    function automatic vec_t fill_vec(input lane_t x);
        vec_t v;
        for (int i = 0; i < int'(LANES); i++) v[i] = x;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < int'(LANES); i++) v[i] = {$urandom, $urandom};
        return v;
    endfunction

    task automatic send_beat(input vec_t v);
        @(negedge CLK);
        D       = v;
        D_VALID = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            D_VALID = 1'b0;
        end
    endtask

    task automatic wait_results(input int n, input int budget);
        int b = 0;
        while (got_q.size() < n && b < budget) begin
            @(negedge CLK);
            b++;
        end
    endtask

    task automatic clear_results();
        got_q.delete();
        got_t.delete();
    endtask

    task automatic test_reset();
        RST = 1'b1; D = '0; D_VALID = 1'b0; LEN = 16'd1; Q_BP = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if ({Q, Q_VALID, D_BP, ERR} !== '0) $display("FAIL reset_state: Q=%h QV=%b BP=%b ERR=%b expected all 0", Q, Q_VALID, D_BP, ERR);
        else passed++;
        RST = 1'b0;
        idle(2);
    endtask

    task automatic test_latency();
        int    pulses = 0;
        int    pos    = -1;
        lane_t qv     = '0;
        clear_results();
        LEN = 16'd1;
        send_beat(seq_vec());
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (k == 1) D_VALID = 1'b0;
            if (Q_VALID === 1'b1) begin
                pulses++;
                pos = k;
                qv  = Q;
            end
        end
        total++;
        if (pulses != 1 || pos != 5) $display("FAIL latency: pulses=%0d at cycle %0d expected 1 at cycle 5", pulses, pos);
        else passed++;
        total++;
        if (qv !== 64'd36) $display("FAIL latency_value: got %0d expected 36", qv);
        else passed++;
    endtask

    task automatic test_back_to_back();
        clear_results();
        LEN = 16'd4;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            D       = (i < 4) ? fill_vec(64'd1) : fill_vec(64'd2);
            D_VALID = 1'b1;
            if (i == 5) LEN = 16'd2;
        end
        idle(1);
        wait_results(2, 40);
        idle(4);
        total++;
        if (got_q.size() != 2) $display("FAIL b2b_count: got %0d results expected 2", got_q.size());
        else passed++;
        if (got_q.size() == 2) begin
            total++;
            if (got_q[0] !== 64'd32 || got_q[1] !== 64'd32) $display("FAIL b2b_values: got %0d,%0d expected 32,32", got_q[0], got_q[1]);
            else passed++;
            total++;
            if (got_t[1] - got_t[0] != 2) $display("FAIL b2b_spacing: got %0d cycles expected 2", got_t[1] - got_t[0]);
            else passed++;
        end
    endtask

    task automatic test_wrap_len0();
        clear_results();
        LEN = 16'd1;
        send_beat(fill_vec(64'hFFFF_FFFF_FFFF_FFFF));
        idle(1);
        wait_results(1, 20);
        LEN = 16'd0;
        send_beat(seq_vec());
        idle(1);
        wait_results(2, 20);
        idle(2);
        total++;
        if (got_q.size() != 2) $display("FAIL wrap_count: got %0d results expected 2", got_q.size());
        else passed++;
        if (got_q.size() == 2) begin
            total++;
            if (got_q[0] !== 64'hFFFF_FFFF_FFFF_FFF8) $display("FAIL wrap_value: got %h expected fffffffffffffff8", got_q[0]);
            else passed++;
            total++;
            if (got_q[1] !== 64'd36) $display("FAIL len0_value: got %0d expected 36", got_q[1]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        lane_t exp_q[$];
        int    bp_early = 0;
        int    sent     = 0;
        int    b        = 0;
        vec_t  v;
        clear_results();
        LEN  = 16'd1;
        Q_BP = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (D_BP !== 1'b0) bp_early++;
            v = rand_vec();
            D = v; D_VALID = 1'b1;
            exp_q.push_back(beat_sum(v));
            sent++;
        end
        idle(1);
        total++;
        if (bp_early != 0 || D_BP !== 1'b1) $display("FAIL bp_threshold: early=%0d D_BP=%b expected 0 early and D_BP=1 at 10", bp_early, D_BP);
        else passed++;
        idle(3);
        total++;
        if (ERR !== 1'b0 || got_q.size() != 0) $display("FAIL bp_hold: ERR=%b results=%0d expected 0 and 0", ERR, got_q.size());
        else passed++;
        Q_BP = 1'b0;
        while (sent < 12 && b < 50) begin
            @(negedge CLK);
            b++;
            if (D_BP === 1'b0) begin
                v = rand_vec();
                D = v; D_VALID = 1'b1;
                exp_q.push_back(beat_sum(v));
                sent++;
            end else begin
                D_VALID = 1'b0;
            end
        end
        idle(1);
        wait_results(12, 100);
        idle(3);
        total++;
        if (got_q.size() != 12) $display("FAIL bp_count: got %0d results expected 12", got_q.size());
        else passed++;
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL bp_value[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
        total++;
        if (ERR !== 1'b0) $display("FAIL bp_err: got ERR=%b expected 0", ERR);
        else passed++;
    endtask

    task automatic test_overflow();
        lane_t exp_q[$];
        vec_t  v;
        clear_results();
        LEN  = 16'd1;
        Q_BP = 1'b1;
        for (int i = 0; i < 17; i++) begin
            v = rand_vec();
            send_beat(v);
            if (i < 16) exp_q.push_back(beat_sum(v));
        end
        idle(1);
        total++;
        if (ERR !== 1'b1) $display("FAIL ovf_err_set: got ERR=%b expected 1", ERR);
        else passed++;
        Q_BP = 1'b0;
        wait_results(17, 60);
        idle(5);
        total++;
        if (got_q.size() != 16) $display("FAIL ovf_count: got %0d results expected 16", got_q.size());
        else passed++;
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL ovf_value[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
        total++;
        if (ERR !== 1'b1) $display("FAIL ovf_err_sticky: got ERR=%b expected 1", ERR);
        else passed++;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        total++;
        if (ERR !== 1'b0 || Q !== '0) $display("FAIL ovf_reset: ERR=%b Q=%h expected 0 and 0", ERR, Q);
        else passed++;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset_mid();
        clear_results();
        LEN  = 16'd4;
        Q_BP = 1'b0;
        send_beat(seq_vec());
        send_beat(seq_vec());
        idle(4);
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        total++;
        if ({Q, Q_VALID, D_BP, ERR} !== '0) $display("FAIL mid_reset_outputs: Q=%h QV=%b BP=%b ERR=%b expected all 0", Q, Q_VALID, D_BP, ERR);
        else passed++;
        @(negedge CLK);
        RST = 1'b0;
        clear_results();
        LEN = 16'd1;
        send_beat(seq_vec());
        idle(1);
        wait_results(1, 20);
        idle(6);
        total++;
        if (got_q.size() != 1) $display("FAIL mid_reset_count: got %0d results expected 1", got_q.size());
        else passed++;
        if (got_q.size() >= 1) begin
            total++;
            if (got_q[0] !== 64'd36) $display("FAIL mid_reset_value: got %0d expected 36", got_q[0]);
            else passed++;
        end
    endtask

    task automatic test_random_packets();
        vec_t  v;
        lane_t exp;
        int    len, l, sent, b;
        for (int p = 0; p < 10; p++) begin
            clear_results();
            len  = $urandom_range(0, 6);
            l    = (len == 0) ? 1 : len;
            LEN  = 16'(len);
            exp  = '0;
            sent = 0;
            b    = 0;
            while (sent < l && b < 200) begin
                @(negedge CLK);
                b++;
                Q_BP = 1'($urandom_range(0, 1));
                if (D_BP === 1'b0 && $urandom_range(0, 3) != 0) begin
                    v = rand_vec();
                    D = v; D_VALID = 1'b1;
                    exp += beat_sum(v);
                    sent++;
                end else begin
                    D_VALID = 1'b0;
                end
            end
            idle(1);
            Q_BP = 1'b0;
            wait_results(1, 60);
            idle(3);
            total++;
            if (got_q.size() != 1) $display("FAIL rand_count[%0d]: got %0d results expected 1 (len %0d)", p, got_q.size(), len);
            else passed++;
            if (got_q.size() >= 1) begin
                total++;
                if (got_q[0] !== exp) $display("FAIL rand_value[%0d]: got %h expected %h (len %0d)", p, got_q[0], exp, len);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_wrap_len0();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_random_packets();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
